instr_fetch_unit: RTL and testbench

Drives instruction fetches from program memory and loads the instruction register. It owns the program counter and issues a request/acknowledge read to memory. On each returned word it asserts the IR load enable with the word on the IR data input for exactly one cycle, then waits for the control unit to finish executing before fetching again. Branch and jump redirects from the control unit are applied at the end of execution.

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction words
// from program memory over a req/ack handshake, and pulses the IR load enable
// once per fetched word. It then waits for the control unit to finish.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              halt,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              ir_en,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              bus_err
);

  // The ack wait counter is 8 bits wide, so the limit is taken modulo 256.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [7:0]        cnt_q, cnt_d;

  // State register, program counter, fetched word and ack-wait counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= {DATA_W{1'b0}};
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; every register holds its value unless a state acts on it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Only start matters here; redirects while idle are dropped.
        if (start) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack wins even on the cycle the counter sits at the limit.
        if (mem_ack) begin
          instr_d = mem_rdata;
          cnt_d   = 8'd0;
          state_d = S_LOAD;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = S_ERROR;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_REQ;
        end
      end
      S_LOAD: begin
        // Post-increment wraps naturally at the top of the address space.
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Redirect and halt are only meaningful at the end of execution;
        // a redirect still applies when the unit halts.
        if (exec_done) begin
          if (pc_load) begin
            pc_d = pc_load_val;
          end else begin
            pc_d = pc_q;
          end
          if (halt) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_ERROR: begin
        // Only reset leaves the error state.
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registers, so no input reaches an output
  // combinationally.
  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = pc_q;
  assign pc_out   = pc_q;
  assign ir_en    = (state_q == S_LOAD);
  assign ir_data  = instr_q;
  assign busy     = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_EXEC);
  assign bus_err  = (state_q == S_ERROR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected requests
// and instruction words; a negedge monitor pops and compares as they appear.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start, halt, exec_done, pc_load;
  logic [15:0] pc_load_val;
  logic        mem_req, mem_ack, ir_en, busy, bus_err;
  logic [15:0] mem_addr, mem_rdata, ir_data, pc_out;

  // second instance with RESET_PC at the top of the address space
  logic        b_start, b_req, b_ir_en, b_busy, b_err;
  logic [15:0] b_addr, b_ir_data, b_pc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [15:0] addr; int len; } req_t;
  req_t        exp_req_q[$];
  logic [15:0] exp_ir_q[$];

  logic [15:0] mem [0:255];
  int          ack_after = 0;   // REQ cycle (1-based) carrying the ack; 0 = never
  logic        force_ack = 1'b0;
  int          resp_cnt  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT(255)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .halt(halt), .exec_done(exec_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir_en(ir_en),
    .ir_data(ir_data), .pc_out(pc_out), .busy(busy), .bus_err(bus_err)
  );

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst_b(rst_b), .start(b_start), .halt(1'b0), .exec_done(1'b0),
    .pc_load(1'b0), .pc_load_val(16'h0000), .mem_req(b_req),
    .mem_addr(b_addr), .mem_rdata(16'h5A5A), .mem_ack(1'b1), .ir_en(b_ir_en),
    .ir_data(b_ir_data), .pc_out(b_pc), .busy(b_busy), .bus_err(b_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks on the configured REQ cycle with the word at mem_addr.
  always @(negedge clk) begin
    if (mem_req) begin
      resp_cnt = resp_cnt + 1;
      if (ack_after != 0 && resp_cnt == ack_after) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[7:0]];
      end else begin
        mem_ack   = force_ack;
        mem_rdata = 16'h0000;
      end
    end else begin
      resp_cnt  = 0;
      mem_ack   = force_ack;
      mem_rdata = 16'hDEAD;
    end
  end

  // Monitor: compares each new request and each IR load against the scoreboard.
  logic prev_req = 1'b0, prev_ir = 1'b0;
  int   cur_len = 0, cur_exp_len = 0;
  always @(negedge clk) begin
    req_t r;
    logic [15:0] w;
    if (mem_req && !prev_req) begin
      if (exp_req_q.size() == 0) begin
        chk("unexpected_req", 32'(mem_addr), 32'hFFFF_FFFF);
        cur_exp_len = 0;
      end else begin
        r = exp_req_q.pop_front();
        chk("req_addr", 32'(mem_addr), 32'(r.addr));
        cur_exp_len = r.len;
      end
      cur_len = 1;
    end else if (mem_req) begin
      cur_len++;
    end
    if (mem_req) chk("addr_eq_pc", 32'(mem_addr), 32'(pc_out));
    if (!mem_req && prev_req && cur_exp_len != 0) chk("req_len", 32'(cur_len), 32'(cur_exp_len));
    if (ir_en) begin
      chk("ir_single_pulse", 32'(prev_ir), 32'd0);
      if (exp_ir_q.size() == 0) begin
        chk("unexpected_ir", 32'(ir_data), 32'hFFFF_FFFF);
      end else begin
        w = exp_ir_q.pop_front();
        chk("ir_data", 32'(ir_data), 32'(w));
      end
    end
    prev_req = mem_req;
    prev_ir  = ir_en;
  end

  task automatic wait_ir(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (ir_en) seen = 1'b1;
    end
    if (!seen) chk("ir_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_exec_done();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    pc_load   = 1'b0;
    halt      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_b = 1'b1; start = 1'b0; halt = 1'b0; exec_done = 1'b0;
    pc_load = 1'b0; pc_load_val = 16'h0000; b_start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h7700;
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'hBEEF; mem[8'h02] = 16'hCAFE;
    mem[8'h40] = 16'h4040; mem[8'h10] = 16'h1010;

    // 1: reset for 5 cycles
    repeat (5) @(negedge clk);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ir_en", 32'(ir_en), 32'd0);
    chk("rst_ir_data", 32'(ir_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_b_pc", 32'(b_pc), 32'hFFFF);
    rst_b = 1'b0;
    @(negedge clk);

    // 5a: PC wraps from 0xFFFF to 0x0000 on the second instance
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_req", 32'(b_req), 32'd1);
    chk("b_addr", 32'(b_addr), 32'hFFFF);
    @(negedge clk);
    chk("b_ir_en", 32'(b_ir_en), 32'd1);
    chk("b_ir_data", 32'(b_ir_data), 32'h5A5A);
    @(negedge clk);
    chk("b_pc_wrap", 32'(b_pc), 32'h0000);
    chk("b_ir_en_low", 32'(b_ir_en), 32'd0);

    // 2: same-cycle ack
    ack_after = 1;
    exp_req_q.push_back('{16'h0000, 1});
    exp_ir_q.push_back(16'h1234);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ir(20);
    @(negedge clk);
    chk("pc_after_fetch0", 32'(pc_out), 32'h0001);
    chk("busy_exec", 32'(busy), 32'd1);

    // 3: ack after 3 REQ cycles
    ack_after = 3;
    exp_req_q.push_back('{16'h0001, 3});
    exp_ir_q.push_back(16'hBEEF);
    pulse_exec_done();
    wait_ir(20);
    @(negedge clk);
    chk("pc_after_fetch1", 32'(pc_out), 32'h0002);

    // 3: ack exactly when the counter reaches 255
    ack_after = 256;
    exp_req_q.push_back('{16'h0002, 256});
    exp_ir_q.push_back(16'hCAFE);
    pulse_exec_done();
    wait_ir(400);
    @(negedge clk);
    chk("pc_after_fetch2", 32'(pc_out), 32'h0003);
    chk("no_err_at_limit", 32'(bus_err), 32'd0);

    // 4: redirect without exec_done is ignored, with exec_done it applies
    ack_after   = 1;
    pc_load     = 1'b1;
    pc_load_val = 16'h0040;
    halt        = 1'b1;
    repeat (2) @(negedge clk);
    chk("pc_load_no_done", 32'(pc_out), 32'h0003);
    chk("halt_no_done_busy", 32'(busy), 32'd1);
    chk("exec_no_req", 32'(mem_req), 32'd0);
    halt = 1'b0;
    exp_req_q.push_back('{16'h0040, 1});
    exp_ir_q.push_back(16'h4040);
    pulse_exec_done();
    wait_ir(20);
    @(negedge clk);
    chk("pc_after_redirect", 32'(pc_out), 32'h0041);

    // 5b: halt together with redirect -> IDLE at the new PC
    pc_load     = 1'b1;
    pc_load_val = 16'h0010;
    halt        = 1'b1;
    pulse_exec_done();
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pc_out), 32'h0010);
    pc_load     = 1'b1;
    pc_load_val = 16'h0077;
    exec_done   = 1'b1;
    repeat (4) @(negedge clk);
    pc_load   = 1'b0;
    exec_done = 1'b0;
    chk("idle_pc_load_ignored", 32'(pc_out), 32'h0010);
    chk("idle_no_req", 32'(mem_req), 32'd0);
    exp_req_q.push_back('{16'h0010, 1});
    exp_ir_q.push_back(16'h1010);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ir(20);
    @(negedge clk);
    chk("pc_after_restart", 32'(pc_out), 32'h0011);

    // 6: reset while a request is outstanding, then a late ack
    ack_after = 0;
    exp_req_q.push_back('{16'h0011, 0});
    pulse_exec_done();
    chk("req_before_rst", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_pc", 32'(pc_out), 32'h0000);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);

    // 3: no ack -> ERROR after the full wait, sticky until reset
    exp_req_q.push_back('{16'h0000, 256});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus_err) seen = 1'b1;
    end
    chk("bus_err_set", 32'(bus_err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    chk("err_sticky", 32'(bus_err), 32'd1);
    chk("err_no_req", 32'(mem_req), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("err_cleared", 32'(bus_err), 32'd0);
    @(negedge clk);

    chk("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    chk("ir_queue_empty", 32'(exp_ir_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
